// File: rtl/disk_chan_pkg.sv
// disk_chan_pkg: shared status/control bit positions and transfer FSM states for the host sector channel
package disk_chan_pkg;
   localparam int SR_RD_A  = 17;
   localparam int SR_RD_B  = 18;
   localparam int SR_WR_A  = 20;
   localparam int SR_WR_B  = 21;
   localparam int SR_ACK   = 16;
   localparam int SR_OWNER = 22;
   localparam int CR_DONE  = 4;
   localparam int CR_ERR   = 3;
   localparam logic [31:0] SR_REQ_MASK = (32'd1 << SR_RD_A) | (32'd1 << SR_RD_B) | (32'd1 << SR_WR_A) | (32'd1 << SR_WR_B);
   localparam logic [31:0] CR_ABORT = (32'd1 << CR_DONE) | (32'd1 << CR_ERR);
   typedef enum logic [2:0] {ST_IDLE, ST_FWD, ST_WAIT_DONE, ST_ABORT, ST_RELEASE} xfer_state_t;
   function automatic logic has_req(input logic [31:0] sr);
      return sr[SR_WR_B] | sr[SR_WR_A] | sr[SR_RD_B] | sr[SR_RD_A];
   endfunction
endpackage

// File: rtl/disk_xfer_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick
// ports: clk, rst_n (sync, active-low); req[1:0] requests; upd/id load the last-granted id; pick = chosen client
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       id,
   output logic       pick
);
   logic last;
   // last starts at 1 so client 0 wins the first contention
   always_ff @(posedge clk)
      if (!rst_n) last <= 1'b1;
      else if (upd) last <= id;
   assign pick = &req ? !last : req[1];
endmodule

// File: rtl/disk_xfer_arbiter.sv
// disk_xfer_arbiter: shares the host sector-transfer channel between two disk-controller clients
// ports: clk, rst_n (sync, active-low); cli_sr/cli_cr status/control per client; cli_data_in + cli_clkin read path,
//        cli_data_out + cli_clkout write path; host_sr/host_cr host words; host_data_in/host_clkin,
//        host_data_out/host_clkout host byte streams; grant_id current owner; busy transaction in flight
module disk_xfer_arbiter
   import disk_chan_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cli_sr       [0:1],
   output logic [31:0] cli_cr       [0:1],
   output logic [7:0]  cli_data_in,
   output logic        cli_clkin    [0:1],
   input  logic [7:0]  cli_data_out [0:1],
   output logic        cli_clkout   [0:1],
   output logic [31:0] host_sr,
   input  logic [31:0] host_cr,
   input  logic [7:0]  host_data_in,
   input  logic        host_clkin,
   output logic [7:0]  host_data_out,
   input  logic        host_clkout,
   output logic        grant_id,
   output logic        busy
);
   localparam logic [23:0] WD_LAST = TIMEOUT_CYCLES - 24'd1;
   xfer_state_t st;
   logic owner, aborted, pick, release_ok, wd_expired, pass, abort_drive, unused_hi;
   logic [1:0] req;
   logic [23:0] wd_cnt;
   logic [31:0] own_sr, fwd_sr, abt_sr;
   assign req = {has_req(cli_sr[1]), has_req(cli_sr[0])};
   assign own_sr = cli_sr[owner];
   assign fwd_sr = {9'b0, owner, own_sr[SR_OWNER-1:0]};
   // after a forced abort the host sees the request withdrawn and acknowledged
   assign abt_sr = (fwd_sr & ~SR_REQ_MASK) | (32'd1 << SR_ACK);
   assign release_ok = !host_cr[CR_DONE] && !req[owner];
   assign wd_expired = TIMEOUT_CYCLES != 24'd0 && wd_cnt == WD_LAST;
   assign pass = st == ST_WAIT_DONE || (st == ST_RELEASE && !aborted);
   assign abort_drive = st == ST_ABORT || (st == ST_RELEASE && aborted && req[owner]);
   assign grant_id = owner;
   assign cli_data_in = host_data_in;
   assign host_data_out = cli_data_out[owner];
   assign unused_hi = ^{cli_sr[0][31:SR_OWNER], cli_sr[1][31:SR_OWNER]};
   rr_arb2 u_rr (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .upd  (st == ST_RELEASE && release_ok),
      .id   (owner),
      .pick (pick)
   );
   always_ff @(posedge clk)
      if (!rst_n) begin
         st      <= ST_IDLE;
         owner   <= 1'b0;
         aborted <= 1'b0;
         wd_cnt  <= '0;
         host_sr <= '0;
         busy    <= 1'b0;
      end else
         case (st)
            ST_IDLE:
               if (|req) begin
                  owner   <= pick;
                  aborted <= 1'b0;
                  wd_cnt  <= '0;
                  busy    <= 1'b1;
                  st      <= ST_FWD;
               end
            ST_FWD: begin
               host_sr <= fwd_sr;
               st      <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               host_sr <= fwd_sr;
               wd_cnt  <= wd_cnt == WD_LAST ? wd_cnt : wd_cnt + 24'd1;
               st      <= host_cr[CR_DONE] ? ST_RELEASE : wd_expired ? ST_ABORT : ST_WAIT_DONE;
            end
            ST_ABORT: begin
               host_sr <= abt_sr;
               aborted <= 1'b1;
               st      <= ST_RELEASE;
            end
            ST_RELEASE:
               if (release_ok) begin
                  host_sr[SR_OWNER:SR_ACK] <= '0;
                  busy <= 1'b0;
                  st   <= ST_IDLE;
               end else host_sr <= aborted ? abt_sr : fwd_sr;
            default: st <= ST_IDLE;
         endcase
   for (genvar g = 0; g < 2; g++) begin : g_cli
      assign cli_clkin[g]  = host_clkin & busy & (owner == 1'(g));
      assign cli_clkout[g] = host_clkout & busy & (owner == 1'(g));
      assign cli_cr[g] = owner != 1'(g) ? '0 : pass ? host_cr : abort_drive ? CR_ABORT : '0;
   end
endmodule

// File: tb/tb_disk_xfer_arbiter.sv
// tb_disk_xfer_arbiter: directed bench with a cycle model for the main instance and literal checks for the watchdog instance
module tb_disk_xfer_arbiter;
   logic clk = 0, rst_n = 0;
   logic [31:0] sr [0:1] = '{32'd0, 32'd0};
   logic [31:0] hcr = 0;
   logic [7:0] hdin = 0;
   logic [7:0] cdo [0:1] = '{8'd0, 8'd0};
   logic hci = 0, hco = 0;
   logic [31:0] ccr [0:1];
   logic [31:0] hsr;
   logic [7:0] cdi, hdo;
   logic cci [0:1];
   logic cco [0:1];
   logic gid, bsy;
   logic [31:0] wsr [0:1] = '{32'd0, 32'd0};
   logic [31:0] w_hcr = 0;
   logic [7:0] w_cdo [0:1] = '{8'd0, 8'd0};
   logic [31:0] wcr [0:1];
   logic [31:0] whsr;
   logic [7:0] wcdi, whdo;
   logic wci [0:1];
   logic wco [0:1];
   logic wgid, wbsy;
   logic w_zero = 0;
   int tests = 0, fails = 0;
   int n_ci0 = 0, n_ci1 = 0, n_co0 = 0, n_co1 = 0;
   always #5 clk = ~clk;

   disk_xfer_arbiter u_dut (
      .clk(clk), .rst_n(rst_n), .cli_sr(sr), .cli_cr(ccr), .cli_data_in(cdi), .cli_clkin(cci),
      .cli_data_out(cdo), .cli_clkout(cco), .host_sr(hsr), .host_cr(hcr), .host_data_in(hdin),
      .host_clkin(hci), .host_data_out(hdo), .host_clkout(hco), .grant_id(gid), .busy(bsy)
   );

   disk_xfer_arbiter #(.TIMEOUT_CYCLES(24'd100)) u_wd (
      .clk(clk), .rst_n(rst_n), .cli_sr(wsr), .cli_cr(wcr), .cli_data_in(wcdi), .cli_clkin(wci),
      .cli_data_out(w_cdo), .cli_clkout(wco), .host_sr(whsr), .host_cr(w_hcr), .host_data_in(8'd0),
      .host_clkin(w_zero), .host_data_out(whdo), .host_clkout(w_zero), .grant_id(wgid), .busy(wbsy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit rq(input logic [31:0] s);
      return s[21] | s[20] | s[18] | s[17];
   endfunction

   // Transaction model: who owns the channel, how many cycles since the grant, and whether done was seen
   bit m_busy = 0, m_own = 0, m_last = 1, m_rel = 0;
   int m_age = 0;
   logic [31:0] m_hsr = 0;
   always @(posedge clk)
      if (!rst_n) begin
         m_busy <= 0;
         m_own  <= 0;
         m_last <= 1;
         m_rel  <= 0;
         m_age  <= 0;
         m_hsr  <= 0;
      end else if (!m_busy) begin
         if (rq(sr[0]) || rq(sr[1])) begin
            m_own  <= (rq(sr[0]) && rq(sr[1])) ? !m_last : rq(sr[1]);
            m_busy <= 1;
            m_age  <= 0;
            m_rel  <= 0;
         end
      end else if (m_rel && !hcr[4] && !rq(sr[m_own])) begin
         m_hsr  <= m_hsr & ~32'h007F_0000;
         m_busy <= 0;
         m_last <= m_own;
      end else begin
         m_hsr <= {9'b0, m_own, sr[m_own][21:0]};
         m_age <= m_age + 1;
         if (m_age > 0 && hcr[4]) m_rel <= 1;
      end

   always @(negedge clk) begin
      chk("m_host_sr", hsr, m_hsr);
      chk("m_busy", 32'(bsy), 32'(m_busy));
      chk("m_grant_id", 32'(gid), 32'(m_own));
      chk("m_cli_cr0", ccr[0], (m_busy && m_age > 0 && m_own == 0) ? hcr : 32'd0);
      chk("m_cli_cr1", ccr[1], (m_busy && m_age > 0 && m_own == 1) ? hcr : 32'd0);
      chk("m_clkin", {30'd0, cci[1], cci[0]}, {30'd0, hci & m_busy & m_own, hci & m_busy & !m_own});
      chk("m_clkout", {30'd0, cco[1], cco[0]}, {30'd0, hco & m_busy & m_own, hco & m_busy & !m_own});
      chk("m_host_data_out", 32'(hdo), 32'(cdo[m_own]));
      chk("m_cli_data_in", 32'(cdi), 32'(hdin));
   end

   always @(negedge clk) begin
      if (cci[0]) n_ci0 <= n_ci0 + 1;
      if (cci[1]) n_ci1 <= n_ci1 + 1;
      if (cco[0]) n_co0 <= n_co0 + 1;
      if (cco[1]) n_co1 <= n_co1 + 1;
   end

   initial begin
      int c0, c1, gap, got, quiet;
      repeat (3) tick;
      @(negedge clk);
      chk("rst_host_sr", hsr, 0);
      chk("rst_busy", 32'(bsy), 0);
      chk("rst_grant", 32'(gid), 0);
      chk("rst_cli_cr0", ccr[0], 0);
      // client 0 read
      tick; rst_n = 1; sr[0] = 32'h0002_0305;
      tick; tick;
      @(negedge clk);
      chk("rd_host_sr", hsr, 32'h0002_0305);
      chk("rd_busy", 32'(bsy), 1);
      c0 = n_ci0; c1 = n_ci1;
      for (int k = 0; k < 512; k++) begin
         tick; hdin = 8'(k); hci = 1;
         tick; hci = 0;
      end
      tick;
      @(negedge clk);
      chk("rd_pulses0", n_ci0 - c0, 512);
      chk("rd_pulses1", n_ci1 - c1, 0);
      tick; hcr = 32'h10;
      @(negedge clk);
      chk("rd_cr0", ccr[0], 32'h10);
      chk("rd_cr1", ccr[1], 0);
      tick; sr[0] = 32'h0001_0305;
      tick; hcr = 0;
      tick;
      @(negedge clk);
      chk("rd_idle", 32'(bsy), 0);
      // record not found
      tick; sr[0] = 32'h0002_0001;
      tick; tick; tick; hcr = 32'h18;
      @(negedge clk);
      chk("rnf_cr0", ccr[0], 32'h18);
      tick; sr[0] = 32'h0001_0001; hcr = 0;
      @(negedge clk);
      chk("rnf_busy_hold", 32'(bsy), 1);
      tick;
      @(negedge clk);
      chk("rnf_busy_fall", 32'(bsy), 0);
      // client 1 write
      tick; sr[0] = 0; sr[1] = 32'h0020_0102; cdo[1] = 8'hA5; cdo[0] = 8'h3C;
      tick; tick; tick;
      @(negedge clk);
      chk("wr_host_data_out", 32'(hdo), 32'hA5);
      chk("wr_grant", 32'(gid), 1);
      chk("wr_host_sr", hsr, 32'h0060_0102);
      c0 = n_co0; c1 = n_co1;
      for (int k = 0; k < 4; k++) begin
         tick; hco = 1;
         tick; hco = 0;
      end
      tick;
      @(negedge clk);
      chk("wr_clkout1", n_co1 - c1, 4);
      chk("wr_clkout0", n_co0 - c0, 0);
      tick; hcr = 32'h10;
      tick; sr[1] = 32'h0001_0102;
      tick; hcr = 0;
      tick; tick;
      @(negedge clk);
      chk("wr_idle", 32'(bsy), 0);
      // contention straight after reset
      tick; sr[1] = 0; rst_n = 0;
      tick; tick; rst_n = 1; sr[0] = 32'h0002_0010; sr[1] = 32'h0004_0020;
      tick; tick;
      @(negedge clk);
      chk("ct_owner_bit0", 32'(hsr[22]), 0);
      chk("ct_host_sr0", hsr, 32'h0002_0010);
      tick; hcr = 32'h10;
      tick; sr[0] = 32'h0001_0010;
      tick; hcr = 0;
      gap = 0; got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         @(negedge clk);
         if (bsy && gid) got = 1;
         else if (!bsy) gap++;
      end
      chk("ct_granted1", got, 1);
      chk("ct_gap", gap, 1);
      tick;
      @(negedge clk);
      chk("ct_host_sr1", hsr, 32'h0044_0020);
      tick; sr[0] = 0; hcr = 32'h10;
      tick; sr[1] = 32'h0001_0020;
      tick; hcr = 0;
      tick; tick; sr[1] = 0;
      // reset in the middle of a transfer
      tick; sr[1] = 32'h0004_0003;
      tick; tick; tick;
      @(negedge clk);
      chk("rs_pre_hsr", hsr, 32'h0044_0003);
      tick; hci = 1; rst_n = 0;
      tick;
      @(negedge clk);
      chk("rs_host_sr", hsr, 0);
      chk("rs_busy", 32'(bsy), 0);
      chk("rs_grant", 32'(gid), 0);
      chk("rs_cli_cr1", ccr[1], 0);
      chk("rs_clkin1", 32'(cci[1]), 0);
      tick; rst_n = 1; hci = 0;
      tick; tick;
      @(negedge clk);
      chk("rs_regrant_hsr", hsr, 32'h0044_0003);
      chk("rs_regrant_busy", 32'(bsy), 1);
      tick; hcr = 32'h10;
      tick; sr[1] = 32'h0001_0003;
      tick; hcr = 0;
      tick; tick; sr[1] = 0;
      // watchdog instance, host silent
      tick; wsr[0] = 32'h0002_0305;
      quiet = 0;
      for (int t = 1; t <= 101; t++) begin
         @(posedge clk);
         @(negedge clk);
         if (wcr[0] != 0 || !wbsy) quiet++;
      end
      chk("wd_quiet", quiet, 0);
      @(posedge clk);
      @(negedge clk);
      chk("wd_abort_cr0", wcr[0], 32'h18);
      chk("wd_abort_cr1", wcr[1], 0);
      @(posedge clk);
      @(negedge clk);
      chk("wd_host_sr", whsr, 32'h0001_0305);
      chk("wd_cr0_held", wcr[0], 32'h18);
      tick; wsr[0] = 0;
      @(negedge clk);
      chk("wd_busy_hold", 32'(wbsy), 1);
      tick;
      @(negedge clk);
      chk("wd_busy_fall", 32'(wbsy), 0);
      chk("wd_host_sr_clr", whsr, 32'h0000_0305);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
